// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_ERR  = 2'd2
  } pctl_state_t;

  localparam int unsigned XZR = 31;

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer: load-use / flag-use bubbles, taken-branch flushes,
// data-memory wait with timeout, and saturating stall/flush counters.
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned REG_W       = 5,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned ZERO_REG    = XZR
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rn,
  input  logic [REG_W-1:0] id_rm,
  input  logic             id_uses_rn,
  input  logic             id_uses_rm,
  input  logic             id_flag_br,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_destreg,
  input  logic             ex_setflags,
  input  logic             mem_br_taken,
  input  logic             mem_access,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             ifde_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifde_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             mem_err,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int unsigned WC_W = $clog2(MEM_TIMEOUT);
  localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(MEM_TIMEOUT - 1);

  pctl_state_t     state_q, state_d;
  logic [WC_W-1:0] wait_q, wait_d;
  logic            err_q, err_d;

  logic       mem_stall;
  logic       load_use, flag_use, run_rules;
  logic [4:0] en_v;
  logic [2:0] fl_v;
  logic       flush_evt, stall_evt;

  assign mem_stall = mem_access & ~dmem_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      wait_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

  // A ready memory beats the timeout when both land on the same cycle.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    err_d   = err_q;
    unique case (state_q)
      RUN: begin
        if (mem_stall) begin
          state_d = MEM_WAIT;
          wait_d  = WC_W'(1);
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          state_d = RUN;
        end else if (wait_q == WAIT_LAST) begin
          state_d = MEM_ERR;
          err_d   = 1'b1;
        end else begin
          wait_d = wait_q + WC_W'(1);
        end
      end
      MEM_ERR: begin
        state_d = MEM_ERR;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // Enable vector order: {pc, ifde, idex, exmem, memwb}; flush: {ifde, idex, exmem}.
  always_comb begin
    load_use = ex_memread && (ex_destreg != REG_W'(ZERO_REG)) &&
               ((id_uses_rn && (id_rn == ex_destreg)) ||
                (id_uses_rm && (id_rm == ex_destreg)));
    flag_use  = ex_setflags & id_flag_br;
    run_rules = (state_q == RUN) || ((state_q == MEM_WAIT) && dmem_ready);
    en_v      = 5'b00000;
    fl_v      = 3'b000;
    flush_evt = 1'b0;
    if (run_rules && !mem_stall) begin
      if (mem_br_taken) begin
        en_v      = 5'b11111;
        fl_v      = 3'b111;
        flush_evt = 1'b1;
      end else if (load_use || flag_use) begin
        en_v = 5'b00111;
        fl_v = 3'b010;
      end else begin
        en_v = 5'b11111;
      end
    end
    if (!reset) begin
      en_v      = 5'b00000;
      fl_v      = 3'b000;
      flush_evt = 1'b0;
    end
  end

  assign stall_evt = reset && (state_q != MEM_ERR) && !en_v[4];

  assign {pc_en, ifde_en, idex_en, exmem_en, memwb_en} = en_v;
  assign {ifde_flush, idex_flush, exmem_flush}         = fl_v;
  assign mem_err = err_q;
  assign state_o = state_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (reset),
    .en    (stall_evt),
    .clr   (1'b0),
    .count (stall_count)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (reset),
    .en    (flush_evt),
    .clr   (1'b0),
    .count (flush_count)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl; a 4-bit-counter copy shares stimulus for saturation.
module tb_pipeline_hazard_ctrl;

  logic       clk;
  logic       reset;
  logic [4:0] id_rn, id_rm, ex_destreg;
  logic       id_uses_rn, id_uses_rm, id_flag_br;
  logic       ex_memread, ex_setflags;
  logic       mem_br_taken, mem_access, dmem_ready;

  logic        pc_en, ifde_en, idex_en, exmem_en, memwb_en;
  logic        ifde_flush, idex_flush, exmem_flush;
  logic        mem_err;
  logic [1:0]  state;
  logic [31:0] stall_count, flush_count;

  logic        pc_en4, ifde_en4, idex_en4, exmem_en4, memwb_en4;
  logic        ifde_flush4, idex_flush4, exmem_flush4;
  logic        mem_err4;
  logic [1:0]  state4;
  logic [3:0]  stall_count4, flush_count4;

  logic [4:0] en_v;
  logic [2:0] fl_v;
  assign en_v = {pc_en, ifde_en, idex_en, exmem_en, memwb_en};
  assign fl_v = {ifde_flush, idex_flush, exmem_flush};

  int n_cmp = 0;
  int n_bad = 0;
  int exp_stall = 0;
  int exp_flush = 0;

  pipeline_hazard_ctrl dut (
    .clk(clk), .reset(reset),
    .id_rn(id_rn), .id_rm(id_rm), .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm),
    .id_flag_br(id_flag_br), .ex_memread(ex_memread), .ex_destreg(ex_destreg),
    .ex_setflags(ex_setflags), .mem_br_taken(mem_br_taken), .mem_access(mem_access),
    .dmem_ready(dmem_ready),
    .pc_en(pc_en), .ifde_en(ifde_en), .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ifde_flush(ifde_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .mem_err(mem_err), .state_o(state), .stall_count(stall_count), .flush_count(flush_count)
  );

  pipeline_hazard_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset),
    .id_rn(id_rn), .id_rm(id_rm), .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm),
    .id_flag_br(id_flag_br), .ex_memread(ex_memread), .ex_destreg(ex_destreg),
    .ex_setflags(ex_setflags), .mem_br_taken(mem_br_taken), .mem_access(mem_access),
    .dmem_ready(dmem_ready),
    .pc_en(pc_en4), .ifde_en(ifde_en4), .idex_en(idex_en4), .exmem_en(exmem_en4), .memwb_en(memwb_en4),
    .ifde_flush(ifde_flush4), .idex_flush(idex_flush4), .exmem_flush(exmem_flush4),
    .mem_err(mem_err4), .state_o(state4), .stall_count(stall_count4), .flush_count(flush_count4)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1);
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rn = 5'd0; id_rm = 5'd0; id_uses_rn = 1'b0; id_uses_rm = 1'b0;
    id_flag_br = 1'b0; ex_memread = 1'b0; ex_destreg = 5'd0; ex_setflags = 1'b0;
    mem_br_taken = 1'b0; mem_access = 1'b0; dmem_ready = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle();
    ex_memread = 1'b1; ex_destreg = 5'd2; id_rn = 5'd2; id_uses_rn = 1'b1; mem_br_taken = 1'b1;
    @(negedge clk);
    n_cmp++; if (en_v !== 5'b00000) begin n_bad++; $display("FAIL reset_en: got %b want %b", en_v, 5'b00000); end
    n_cmp++; if (fl_v !== 3'b000) begin n_bad++; $display("FAIL reset_flush: got %b want %b", fl_v, 3'b000); end
    n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", state); end
    n_cmp++; if (mem_err !== 1'b0) begin n_bad++; $display("FAIL reset_mem_err: got %b want 0", mem_err); end
    n_cmp++; if (stall_count !== 32'd0 || flush_count !== 32'd0) begin n_bad++; $display("FAIL reset_counts: got %0d/%0d want 0/0", stall_count, flush_count); end
    tick();
    reset = 1'b1;
    idle();
  endtask

  task automatic test_load_use();
    idle(); ex_memread = 1'b1; ex_destreg = 5'd1; id_rn = 5'd1; id_uses_rn = 1'b1;
    @(negedge clk);
    n_cmp++; if (en_v !== 5'b00111) begin n_bad++; $display("FAIL lu_rn_en: got %b want %b", en_v, 5'b00111); end
    n_cmp++; if (fl_v !== 3'b010) begin n_bad++; $display("FAIL lu_rn_flush: got %b want %b", fl_v, 3'b010); end
    tick(); exp_stall++;
    idle();
    @(negedge clk);
    n_cmp++; if (en_v !== 5'b11111) begin n_bad++; $display("FAIL lu_after_en: got %b want %b", en_v, 5'b11111); end
    n_cmp++; if (stall_count !== 32'(exp_stall)) begin n_bad++; $display("FAIL lu_stall_cnt: got %0d want %0d", stall_count, exp_stall); end
    tick();
    idle(); ex_memread = 1'b1; ex_destreg = 5'd7; id_rn = 5'd3; id_uses_rn = 1'b1; id_rm = 5'd7; id_uses_rm = 1'b1;
    @(negedge clk);
    n_cmp++; if (en_v !== 5'b00111) begin n_bad++; $display("FAIL lu_rm_en: got %b want %b", en_v, 5'b00111); end
    tick(); exp_stall++;
    idle(); ex_memread = 1'b1; ex_destreg = 5'd7; id_rm = 5'd7; id_uses_rm = 1'b0;
    @(negedge clk);
    n_cmp++; if (en_v !== 5'b11111) begin n_bad++; $display("FAIL lu_rm_unused_en: got %b want %b", en_v, 5'b11111); end
    n_cmp++; if (stall_count !== 32'(exp_stall)) begin n_bad++; $display("FAIL lu_rm_stall_cnt: got %0d want %0d", stall_count, exp_stall); end
    tick();
  endtask

  task automatic test_zero_reg();
    idle(); ex_memread = 1'b1; ex_destreg = 5'd31; id_rn = 5'd31; id_uses_rn = 1'b1; id_rm = 5'd31; id_uses_rm = 1'b1;
    @(negedge clk);
    n_cmp++; if (en_v !== 5'b11111 || fl_v !== 3'b000) begin n_bad++; $display("FAIL xzr_no_stall: got %b/%b want 11111/000", en_v, fl_v); end
    tick();
    idle(); ex_memread = 1'b0; ex_destreg = 5'd9; id_rn = 5'd9; id_uses_rn = 1'b1;
    @(negedge clk);
    n_cmp++; if (en_v !== 5'b11111) begin n_bad++; $display("FAIL non_load_no_stall: got %b want 11111", en_v); end
    n_cmp++; if (stall_count !== 32'(exp_stall)) begin n_bad++; $display("FAIL xzr_stall_cnt: got %0d want %0d", stall_count, exp_stall); end
    tick();
  endtask

  task automatic test_flag_branch();
    idle(); ex_setflags = 1'b1; id_flag_br = 1'b1;
    @(negedge clk);
    n_cmp++; if (en_v !== 5'b00111 || fl_v !== 3'b010) begin n_bad++; $display("FAIL flag_use: got %b/%b want 00111/010", en_v, fl_v); end
    tick(); exp_stall++;
    mem_br_taken = 1'b1;
    ex_memread = 1'b1; ex_destreg = 5'd4; id_rn = 5'd4; id_uses_rn = 1'b1;
    @(negedge clk);
    n_cmp++; if (en_v !== 5'b11111) begin n_bad++; $display("FAIL branch_en: got %b want 11111", en_v); end
    n_cmp++; if (fl_v !== 3'b111) begin n_bad++; $display("FAIL branch_flush: got %b want 111", fl_v); end
    tick(); exp_flush++;
    idle();
    @(negedge clk);
    n_cmp++; if (flush_count !== 32'(exp_flush)) begin n_bad++; $display("FAIL branch_flush_cnt: got %0d want %0d", flush_count, exp_flush); end
    n_cmp++; if (stall_count !== 32'(exp_stall)) begin n_bad++; $display("FAIL branch_stall_cnt: got %0d want %0d", stall_count, exp_stall); end
    tick();
  endtask

  task automatic test_mem_wait();
    logic [1:0] exp_st;
    idle(); mem_access = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_st = (i == 0) ? 2'd0 : 2'd1;
      @(negedge clk);
      n_cmp++; if (state !== exp_st) begin n_bad++; $display("FAIL wait_state_%0d: got %0d want %0d", i, state, exp_st); end
      n_cmp++; if (en_v !== 5'b00000 || fl_v !== 3'b000) begin n_bad++; $display("FAIL wait_en_%0d: got %b/%b want 00000/000", i, en_v, fl_v); end
      tick(); exp_stall++;
    end
    dmem_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (state !== 2'd1 || en_v !== 5'b11111) begin n_bad++; $display("FAIL wait_release: got st%0d en%b want st1 en11111", state, en_v); end
    tick();
    idle();
    @(negedge clk);
    n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL wait_back_run: got %0d want 0", state); end
    n_cmp++; if (stall_count !== 32'(exp_stall)) begin n_bad++; $display("FAIL wait_stall_cnt: got %0d want %0d", stall_count, exp_stall); end
    tick();
  endtask

  task automatic test_back_to_back();
    idle(); mem_access = 1'b1; dmem_ready = 1'b0;
    tick(); exp_stall++;
    @(negedge clk);
    n_cmp++; if (state !== 2'd1) begin n_bad++; $display("FAIL b2b_wait_state: got %0d want 1", state); end
    tick(); exp_stall++;
    dmem_ready = 1'b1; ex_memread = 1'b1; ex_destreg = 5'd4; id_rn = 5'd4; id_uses_rn = 1'b1;
    @(negedge clk);
    n_cmp++; if (en_v !== 5'b00111 || fl_v !== 3'b010) begin n_bad++; $display("FAIL b2b_release_hazard: got %b/%b want 00111/010", en_v, fl_v); end
    tick(); exp_stall++;
    idle(); mem_access = 1'b1; mem_br_taken = 1'b1; dmem_ready = 1'b0;
    @(negedge clk);
    n_cmp++; if (state !== 2'd0 || en_v !== 5'b00000 || fl_v !== 3'b000) begin n_bad++; $display("FAIL b2b_access_beats_br: got st%0d %b/%b want st0 00000/000", state, en_v, fl_v); end
    tick(); exp_stall++;
    dmem_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (state !== 2'd1 || en_v !== 5'b11111 || fl_v !== 3'b111) begin n_bad++; $display("FAIL b2b_release_br: got st%0d %b/%b want st1 11111/111", state, en_v, fl_v); end
    tick(); exp_flush++;
    idle();
    @(negedge clk);
    n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL b2b_state: got %0d want 0", state); end
    n_cmp++; if (stall_count !== 32'(exp_stall) || flush_count !== 32'(exp_flush)) begin n_bad++; $display("FAIL b2b_counts: got %0d/%0d want %0d/%0d", stall_count, flush_count, exp_stall, exp_flush); end
    tick();
  endtask

  task automatic test_ready_at_timeout();
    idle(); mem_access = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick(); exp_stall++;
    end
    dmem_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (state !== 2'd1 || en_v !== 5'b11111) begin n_bad++; $display("FAIL ready_beats_to: got st%0d en%b want st1 en11111", state, en_v); end
    tick();
    idle();
    @(negedge clk);
    n_cmp++; if (state !== 2'd0 || mem_err !== 1'b0) begin n_bad++; $display("FAIL ready_beats_to_run: got st%0d err%b want st0 err0", state, mem_err); end
    n_cmp++; if (stall_count !== 32'(exp_stall)) begin n_bad++; $display("FAIL ready_to_stall_cnt: got %0d want %0d", stall_count, exp_stall); end
    tick();
  endtask

  task automatic test_timeout();
    idle(); mem_access = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      n_cmp++; if (mem_err !== 1'b0 || en_v !== 5'b00000) begin n_bad++; $display("FAIL to_pre_%0d: got err%b en%b want err0 en00000", i, mem_err, en_v); end
      tick(); exp_stall++;
    end
    @(negedge clk);
    n_cmp++; if (state !== 2'd2 || mem_err !== 1'b1) begin n_bad++; $display("FAIL to_err: got st%0d err%b want st2 err1", state, mem_err); end
    n_cmp++; if (stall_count !== 32'(exp_stall)) begin n_bad++; $display("FAIL to_stall_cnt: got %0d want %0d", stall_count, exp_stall); end
    dmem_ready = 1'b1;
    tick(); tick();
    @(negedge clk);
    n_cmp++; if (state !== 2'd2 || en_v !== 5'b00000 || fl_v !== 3'b000) begin n_bad++; $display("FAIL to_err_hold: got st%0d %b/%b want st2 00000/000", state, en_v, fl_v); end
    n_cmp++; if (stall_count !== 32'(exp_stall)) begin n_bad++; $display("FAIL to_stall_frozen: got %0d want %0d", stall_count, exp_stall); end
    #1 reset = 1'b0;
    #1;
    n_cmp++; if (state !== 2'd0 || mem_err !== 1'b0) begin n_bad++; $display("FAIL to_reset_state: got st%0d err%b want st0 err0", state, mem_err); end
    n_cmp++; if (stall_count !== 32'd0 || flush_count !== 32'd0 || stall_count4 !== 4'd0) begin n_bad++; $display("FAIL to_reset_counts: got %0d/%0d/%0d want 0/0/0", stall_count, flush_count, stall_count4); end
    n_cmp++; if (en_v !== 5'b00000) begin n_bad++; $display("FAIL to_reset_en: got %b want 00000", en_v); end
    tick();
    reset = 1'b1;
    idle();
    exp_stall = 0;
    exp_flush = 0;
  endtask

  task automatic test_saturate();
    idle(); ex_memread = 1'b1; ex_destreg = 5'd5; id_rm = 5'd5; id_uses_rm = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i == 14) begin
        @(negedge clk);
        n_cmp++; if (stall_count4 !== 4'd14) begin n_bad++; $display("FAIL sat_mid: got %0d want 14", stall_count4); end
      end
      tick(); exp_stall++;
    end
    idle();
    @(negedge clk);
    n_cmp++; if (stall_count4 !== 4'd15) begin n_bad++; $display("FAIL sat_4bit: got %0d want 15", stall_count4); end
    n_cmp++; if (stall_count !== 32'(exp_stall)) begin n_bad++; $display("FAIL sat_32bit: got %0d want %0d", stall_count, exp_stall); end
    tick();
  endtask

  // Sequence and final report
  initial begin
    test_reset();
    test_load_use();
    test_zero_reg();
    test_flag_branch();
    test_mem_wait();
    test_back_to_back();
    test_ready_at_timeout();
    test_timeout();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
